// File: rtl/retospect_spike_encoder.sv
// Spike encoder: rising axon edges become {timestamp, idx} events that are queued and sent out over valid/ready.
// Optional macro SPIKE_ENC_TIMESTAMP_EN builds the timestamp counter; without it the TS field reads 0.
module retospect_spike_encoder #(
  parameter int unsigned N_CELLS = 25,
  parameter int unsigned IDX_W   = 5,
  parameter int unsigned TS_W    = 5,
  parameter int unsigned DEPTH   = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    config_en,
  input  logic [N_CELLS-1:0]      axon,
  output logic [TS_W+IDX_W-1:0]   out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    overflow,
  input  logic                    clear_ovf
);

  localparam int unsigned OUT_W = TS_W + IDX_W;
`ifdef SPIKE_ENC_TIMESTAMP_EN
  localparam int unsigned ENT_W = TS_W + IDX_W;
`else
  localparam int unsigned ENT_W = IDX_W;
`endif
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [N_CELLS-1:0] prev_q, pending_q, pending_d;
  logic [ENT_W-1:0]   mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [ENT_W-1:0]   head_q, head_d, push_data;
  logic               valid_q, ovf_q, ovf_d;

  logic [N_CELLS-1:0] rise, grant_oh;
  logic [IDX_W-1:0]   grant_idx;
  logic               grant_found, push, pop, full, can_push, drop;

  assign rise     = config_en ? '0 : (axon & ~prev_q);
  assign pop      = valid_q & out_ready;
  assign full     = (count_q == CNT_W'(DEPTH));
  assign can_push = ~full | pop;

  // Lowest pending index wins the single push slot.
  always_comb begin
    grant_idx   = '0;
    grant_found = 1'b0;
    for (int unsigned i = 0; i < N_CELLS; i++) begin
      if (pending_q[i] && !grant_found) begin
        grant_idx   = IDX_W'(i);
        grant_found = 1'b1;
      end
    end
  end

  assign push     = grant_found & can_push;
  assign grant_oh = push ? (N_CELLS'(1) << grant_idx) : '0;
  assign drop     = |(rise & pending_q & ~grant_oh);

`ifdef SPIKE_ENC_TIMESTAMP_EN
  logic [TS_W-1:0] ts_q;
  assign push_data = {ts_q, grant_idx};

  always_ff @(posedge clk) begin
    if (!rst_n)          ts_q <= '0;
    else if (!config_en) ts_q <= ts_q + TS_W'(1);
  end
`else
  assign push_data = grant_idx;
`endif

  always_comb begin
    pending_d = (pending_q & ~grant_oh) | rise;
    wr_ptr_d  = wr_ptr_q + PTR_W'(push);
    rd_ptr_d  = rd_ptr_q + PTR_W'(pop);
    count_d   = count_q + CNT_W'(push) - CNT_W'(pop);
    ovf_d     = clear_ovf ? 1'b0 : (ovf_q | drop);
  end

  // Next head: a push landing on the new read slot is forwarded into the head register.
  always_comb begin
    head_d = '0;
    if (count_d != '0) begin
      if (push && (wr_ptr_q == rd_ptr_d)) head_d = push_data;
      else                                head_d = mem_q[rd_ptr_d];
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prev_q    <= '0;
      pending_q <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      head_q    <= '0;
      valid_q   <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      prev_q    <= axon;
      pending_q <= pending_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      head_q    <= head_d;
      valid_q   <= (count_d != '0);
      ovf_q     <= ovf_d;
    end
  end

  assign out_data  = OUT_W'(head_q);
  assign out_valid = valid_q;
  assign overflow  = ovf_q;

endmodule
